// File: rtl/ucsbece154a_rf_sb.sv
// Register file with a per-register pending-write scoreboard (busy bits, busy count, sticky error).
// Latency: reads are combinational (0 cycles); writes, reservations, nbusy_o and err_o update on the clock edge.
// No backpressure: every write and reserve is accepted; misuse is flagged on err_o. Option macro: RF_BYPASS_EN.
module ucsbece154a_rf_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] a1_i,
    input  logic [ADDR_W-1:0] a2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic              busy1_o,
    output logic              busy2_o,
    input  logic              we3_i,
    input  logic [ADDR_W-1:0] a3_i,
    input  logic [DATA_W-1:0] wd3_i,
    input  logic              rsv_i,
    input  logic [ADDR_W-1:0] rsv_a_i,
    output logic [ADDR_W:0]   nbusy_o,
    output logic              err_o
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [ADDR_W:0]   nbusy_q;
    logic              err_q;

    logic wr_ok;
    logic rsv_ok;
    logic same_addr;
    logic cnt_inc;
    logic cnt_dec;
    logic err_set;

    // Register 0 is hard-wired to zero (never written, never busy) when ZERO_REG is set.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Qualify the write and reserve requests and work out the scoreboard deltas.
    always_comb begin
        wr_ok     = we3_i && writable(a3_i);
        rsv_ok    = rsv_i && writable(rsv_a_i);
        same_addr = wr_ok && rsv_ok && (a3_i == rsv_a_i);
        // A same-address write+reserve leaves the bit set: a new producer replaces the old one.
        cnt_inc   = rsv_ok && !busy_q[rsv_a_i];
        cnt_dec   = wr_ok && busy_q[a3_i] && !same_addr;
        err_set   = (rsv_ok && busy_q[rsv_a_i] && !same_addr) ||
                    (wr_ok && !busy_q[a3_i]);
        busy_d    = busy_q;
        if (wr_ok) begin
            busy_d[a3_i] = 1'b0;
        end
        // Reserve applied last so it wins over a same-cycle write to the same register.
        if (rsv_ok) begin
            busy_d[rsv_a_i] = 1'b1;
        end
    end

    // Data storage: async clear, write-back on the clock edge.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[a3_i] <= wd3_i;
        end
    end

    // Scoreboard state: busy bits, busy population count and sticky error.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            nbusy_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            nbusy_q <= nbusy_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign nbusy_o = nbusy_q;
    assign err_o   = err_q;

`ifdef RF_BYPASS_EN
    logic byp_ok;
    logic byp_rsv;

    // Forward the in-flight write-back to matching readers; gated so outputs stay 0 in reset.
    always_comb begin
        byp_ok  = wr_ok && rst_ni;
        byp_rsv = same_addr;
        rd1_o   = mem[a1_i];
        busy1_o = busy_q[a1_i];
        rd2_o   = mem[a2_i];
        busy2_o = busy_q[a2_i];
        if (byp_ok && (a1_i == a3_i)) begin
            rd1_o   = wd3_i;
            busy1_o = byp_rsv;
        end
        if (byp_ok && (a2_i == a3_i)) begin
            rd2_o   = wd3_i;
            busy2_o = byp_rsv;
        end
    end
`else
    // Reads reflect stored state only; a write becomes visible after its edge.
    always_comb begin
        rd1_o   = mem[a1_i];
        busy1_o = busy_q[a1_i];
        rd2_o   = mem[a2_i];
        busy2_o = busy_q[a2_i];
    end
`endif

endmodule

// File: tb/tb_ucsbece154a_rf_sb.sv
module tb_ucsbece154a_rf_sb;

    logic        clk;
    logic        rst_ni;
    logic [4:0]  a1_i, a2_i, a3_i, rsv_a_i;
    logic [31:0] rd1_o, rd2_o, wd3_i;
    logic        busy1_o, busy2_o, we3_i, rsv_i, err_o;
    logic [5:0]  nbusy_o;

    int checks = 0;
    int errors = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    ucsbece154a_rf_sb dut (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .a1_i    (a1_i),
        .a2_i    (a2_i),
        .rd1_o   (rd1_o),
        .rd2_o   (rd2_o),
        .busy1_o (busy1_o),
        .busy2_o (busy2_o),
        .we3_i   (we3_i),
        .a3_i    (a3_i),
        .wd3_i   (wd3_i),
        .rsv_i   (rsv_i),
        .rsv_a_i (rsv_a_i),
        .nbusy_o (nbusy_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Record an expected value at stimulus time.
    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    // Compare the next expected value against an observed DUT output.
    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we3_i = 1'b0;
        rsv_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        a1_i = 5'd0; a2_i = 5'd0; a3_i = 5'd0; rsv_a_i = 5'd0;
        wd3_i = 32'd0; we3_i = 1'b0; rsv_i = 1'b0;

        // Reset state
        a1_i = 5'd7; a2_i = 5'd12;
        sb_push("rst_rd1", 0); sb_push("rst_busy2", 0);
        sb_push("rst_nbusy", 0); sb_push("rst_err", 0);
        #3;
        sb_pop(rd1_o); sb_pop({31'd0, busy2_o}); sb_pop({26'd0, nbusy_o}); sb_pop({31'd0, err_o});
        #9;
        rst_ni = 1'b1;
        tick();

        // Reserve r8 then write it back
        rsv_i = 1'b1; rsv_a_i = 5'd8;
        tick(); idle();
        a1_i = 5'd8;
        sb_push("t2_busy1", 1); sb_push("t2_nbusy", 1);
        #1;
        sb_pop({31'd0, busy1_o}); sb_pop({26'd0, nbusy_o});
        we3_i = 1'b1; a3_i = 5'd8; wd3_i = 32'hDEADBEEF;
        sb_push("t2_rd1", 32'hDEADBEEF); sb_push("t2_busy1_clr", 0);
        sb_push("t2_nbusy_clr", 0); sb_push("t2_err", 0);
        tick(); idle();
        sb_pop(rd1_o); sb_pop({31'd0, busy1_o}); sb_pop({26'd0, nbusy_o}); sb_pop({31'd0, err_o});

        // Register 0 ignores reserve and write
        rsv_i = 1'b1; rsv_a_i = 5'd0; we3_i = 1'b1; a3_i = 5'd0; wd3_i = 32'h1234;
        sb_push("t3_rd1", 0); sb_push("t3_busy1", 0); sb_push("t3_nbusy", 0); sb_push("t3_err", 0);
        tick(); idle();
        a1_i = 5'd0;
        #1;
        sb_pop(rd1_o); sb_pop({31'd0, busy1_o}); sb_pop({26'd0, nbusy_o}); sb_pop({31'd0, err_o});

        // Write-back of r9 seen on read port 2 before and after the edge
        rsv_i = 1'b1; rsv_a_i = 5'd9;
        tick(); idle();
        a2_i = 5'd9; we3_i = 1'b1; a3_i = 5'd9; wd3_i = 32'hCAFE;
`ifdef RF_BYPASS_EN
        sb_push("t6_rd2_pre", 32'hCAFE); sb_push("t6_busy2_pre", 0);
`else
        sb_push("t6_rd2_pre", 0); sb_push("t6_busy2_pre", 1);
`endif
        #1;
        sb_pop(rd2_o); sb_pop({31'd0, busy2_o});
        sb_push("t6_rd2_post", 32'hCAFE); sb_push("t6_busy2_post", 0); sb_push("t6_nbusy", 0);
        tick(); idle();
        sb_pop(rd2_o); sb_pop({31'd0, busy2_o}); sb_pop({26'd0, nbusy_o});

        // Same-cycle write+reserve keeps r5 busy; a second reserve flags an error
        rsv_i = 1'b1; rsv_a_i = 5'd5;
        tick();
        we3_i = 1'b1; a3_i = 5'd5; wd3_i = 32'h55;
        sb_push("t4_rd1", 32'h55); sb_push("t4_busy1", 1); sb_push("t4_nbusy", 1); sb_push("t4_err", 0);
        tick(); idle();
        a1_i = 5'd5;
        #1;
        sb_pop(rd1_o); sb_pop({31'd0, busy1_o}); sb_pop({26'd0, nbusy_o}); sb_pop({31'd0, err_o});
        rsv_i = 1'b1; rsv_a_i = 5'd5;
        sb_push("t4_err_dup", 1); sb_push("t4_nbusy_dup", 1);
        tick(); idle();
        sb_pop({31'd0, err_o}); sb_pop({26'd0, nbusy_o});

        // Asynchronous reset mid-cycle clears everything without a clock edge
        a1_i = 5'd8; a2_i = 5'd5;
        #3;
        rst_ni = 1'b0;
        sb_push("t1_rd1", 0); sb_push("t1_rd2", 0); sb_push("t1_busy2", 0);
        sb_push("t1_nbusy", 0); sb_push("t1_err", 0);
        #1;
        sb_pop(rd1_o); sb_pop(rd2_o); sb_pop({31'd0, busy2_o});
        sb_pop({26'd0, nbusy_o}); sb_pop({31'd0, err_o});
        tick();
        rst_ni = 1'b1;
        tick();

        // Reserve every writable register, then write them all back
        for (int r = 1; r < 32; r++) begin
            rsv_i = 1'b1; rsv_a_i = 5'(r);
            tick();
        end
        idle();
        a1_i = 5'd31; a2_i = 5'd1;
        sb_push("t5_nbusy_full", 31); sb_push("t5_busy1", 1); sb_push("t5_busy2", 1); sb_push("t5_err_full", 0);
        #1;
        sb_pop({26'd0, nbusy_o}); sb_pop({31'd0, busy1_o}); sb_pop({31'd0, busy2_o}); sb_pop({31'd0, err_o});
        for (int r = 31; r >= 1; r--) begin
            we3_i = 1'b1; a3_i = 5'(r); wd3_i = 32'h1111_0000 + 32'(r);
            tick();
        end
        idle();
        a1_i = 5'd17; a2_i = 5'd31;
        sb_push("t5_nbusy_empty", 0); sb_push("t5_rd1", 32'h1111_0011);
        sb_push("t5_rd2", 32'h1111_001F); sb_push("t5_err_empty", 0);
        #1;
        sb_pop({26'd0, nbusy_o}); sb_pop(rd1_o); sb_pop(rd2_o); sb_pop({31'd0, err_o});
        we3_i = 1'b1; a3_i = 5'd3; wd3_i = 32'hABCD;
        sb_push("t5_err_wr", 1); sb_push("t5_nbusy_wr", 0); sb_push("t5_rd_wr", 32'hABCD);
        tick(); idle();
        a1_i = 5'd3;
        #1;
        sb_pop({31'd0, err_o}); sb_pop({26'd0, nbusy_o}); sb_pop(rd1_o);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
